cp0_regfile: RTL
================

CP0_REGFILE -- requirements
Module: cp0_regfile

Interface
REQ-001 SHALL provide: clk  in  1  rising-edge clock.
REQ-002 SHALL provide: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL provide: we_i  in  1  MTC0 write enable (M stage).
REQ-004 SHALL provide: waddr_i  in  5  MTC0 target register number.
REQ-005 SHALL provide: raddr_i  in  5  MFC0 source register number.
REQ-006 SHALL provide: data_i  in  32  MTC0 write data.
REQ-007 SHALL provide: int_i  in  6  external hardware interrupt lines.
REQ-008 SHALL provide: excepttype_i  in  32  exception code from the exception unit: 0 none, 1 int, 4 AdEL, 5 AdES, 8 Sys, 9 Bp, 0xa RI, 0xc Ov, 0xe eret.
REQ-009 SHALL provide: current_inst_addr_i  in  32  PC of the M-stage instruction.
REQ-010 SHALL provide: is_in_delayslot_i  in  1  M-stage instruction is in a delay slot.
REQ-011 SHALL provide: bad_addr_i  in  32  faulting address for AdEL/AdES.
REQ-012 SHALL provide: data_o  out  32  combinational read of register raddr_i; 0 for unimplemented numbers.
REQ-013 SHALL provide: count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o  out  32 each  current register values.
REQ-014 SHALL provide: timer_int_o  out  1  sticky timer interrupt flag.

Function
REQ-015 Implemented registers SHALL be: BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14).
REQ-016 Count SHALL increment by 1 every second clock, using a 1-bit tick toggling each cycle; wrap 0xFFFF_FFFF -> 0.
REQ-017 When Count == Compare and Compare != 0, timer_int_o SHALL be set on the next edge and stay set until an MTC0 to Compare clears it.
REQ-018 Cause[15:10] SHALL be sampled from int_i every cycle; Cause[15] SHALL be int_i[5] OR timer_int_o.
REQ-019 MTC0 writable fields: Count all bits; Compare all bits; Status bits 22, 15:8, 1, 0 only; Cause bits 9:8 only; EPC all bits; BadVAddr read-only.
REQ-020 MTC0 to Count in the same cycle as an increment SHALL load data_i; the increment is dropped.
REQ-021 When excepttype_i != 0, MTC0 in that cycle SHALL be suppressed.
REQ-022 Exception types 1,4,5,8,9,0xa,0xc SHALL, on the next edge: set Status.EXL(bit1); write Cause.ExcCode[6:2] (1 maps to 0, others to own value); if EXL was 0, write EPC = PC, or PC-4 when in delay slot, and Cause.BD(bit31) = is_in_delayslot_i.
REQ-023 If EXL was already 1 at exception, EPC and Cause.BD SHALL be unchanged.
REQ-024 Types 4 and 5 SHALL additionally load BadVAddr with bad_addr_i.
REQ-025 Type 0xe (eret) SHALL clear Status.EXL only; all other registers are unchanged.
REQ-026 Unlisted nonzero excepttype_i values SHALL be ignored.
REQ-027 data_o SHALL return the pre-edge value; no write-to-read bypass.

Reset
REQ-028 On rst at a rising edge: Status = 0x0040_0000 (BEV=1), Cause = 0, EPC = 0, BadVAddr = 0, Count = 0, Compare = 0, tick = 0, timer_int_o = 0.
REQ-029 rst SHALL override MTC0, exceptions and counting in the same cycle.

Configuration
REQ-030 Macro CP0_TIMER_INT_EN: when defined, REQ-017 timer logic is present and ORed into Cause[15].
REQ-031 When CP0_TIMER_INT_EN is undefined: timer_int_o is held 0; Cause[15] = int_i[5]; Count/Compare remain readable and writable.

Verification
REQ-032 Reset, then 10 idle cycles -> Count = 5, Status = 0x0040_0000, all other outputs 0.
REQ-033 MTC0 Compare = 8, then run -> timer_int_o = 1 one cycle after Count = 8; Cause[15] = 1; MTC0 Compare = 0x20 -> timer_int_o = 0 next cycle.
REQ-034 excepttype_i = 4, PC = 0xBFC0_0100, delay slot = 1, bad_addr_i = 0x1 -> EPC = 0xBFC0_00FC, Cause = 0x8000_0010, BadVAddr = 0x1, Status.EXL = 1.
REQ-035 Second exception (type 8) with EXL = 1 -> EPC unchanged, ExcCode = 8; then eret (0xe) -> EXL = 0, EPC unchanged.
REQ-036 we_i = 1 to Status with data 0xFFFF_FFFF in the same cycle as excepttype_i = 0xc -> Status = 0x0040_0002, Cause.ExcCode = 0xc.

Source files
------------

// File: rtl/cp0_regfile_if.sv
// Bus between the pipeline and the CP0 register file: MTC0/MFC0 ports,
// exception info from the M stage, and the register value outputs.
interface cp0_regfile_if;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [4:0]  raddr_i;
    logic [31:0] data_i;
    logic [5:0]  int_i;
    logic [31:0] excepttype_i;
    logic [31:0] current_inst_addr_i;
    logic        is_in_delayslot_i;
    logic [31:0] bad_addr_i;
    logic [31:0] data_o;
    logic [31:0] count_o;
    logic [31:0] compare_o;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic [31:0] badvaddr_o;
    logic        timer_int_o;

    modport master (
        output we_i, waddr_i, raddr_i, data_i, int_i, excepttype_i,
               current_inst_addr_i, is_in_delayslot_i, bad_addr_i,
        input  data_o, count_o, compare_o, status_o, cause_o, epc_o,
               badvaddr_o, timer_int_o
    );

    modport slave (
        input  we_i, waddr_i, raddr_i, data_i, int_i, excepttype_i,
               current_inst_addr_i, is_in_delayslot_i, bad_addr_i,
        output data_o, count_o, compare_o, status_o, cause_o, epc_o,
               badvaddr_o, timer_int_o
    );
endinterface

// File: rtl/cp0_regfile.sv
// MIPS CP0 register file: BadVAddr, Count, Compare, Status, Cause, EPC.
// Define CP0_TIMER_INT_EN to enable the Count/Compare timer interrupt.
module cp0_regfile (
    input  logic         clk,
    input  logic         rst,
    cp0_regfile_if.slave bus
);
    localparam logic [4:0]  REG_BADVADDR = 5'd8;
    localparam logic [4:0]  REG_COUNT    = 5'd9;
    localparam logic [4:0]  REG_COMPARE  = 5'd11;
    localparam logic [4:0]  REG_STATUS   = 5'd12;
    localparam logic [4:0]  REG_CAUSE    = 5'd13;
    localparam logic [4:0]  REG_EPC      = 5'd14;
    localparam logic [31:0] STATUS_RST   = 32'h0040_0000;
    localparam logic [31:0] STATUS_WMASK = 32'h0040_FF03;
    localparam logic [31:0] EXC_ERET     = 32'h0000_000E;

    logic [31:0] count, compare, status, cause, epc, badvaddr;
    logic        tick;
    logic        timer_int;

    // Exception types that trap; anything else nonzero is ignored.
    function automatic logic is_trap(input logic [31:0] t);
        case (t)
            32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'hA, 32'hC: is_trap = 1'b1;
            default: is_trap = 1'b0;
        endcase
    endfunction

    function automatic logic [4:0] exc_code(input logic [31:0] t);
        exc_code = (t == 32'h1) ? 5'd0 : t[4:0];
    endfunction

    logic trap, eret, mtc0;
    logic wr_count, wr_compare, wr_status, wr_cause, wr_epc;

    always_comb begin
        trap       = is_trap(bus.excepttype_i);
        eret       = (bus.excepttype_i == EXC_ERET);
        mtc0       = bus.we_i && (bus.excepttype_i == 32'h0);
        wr_count   = mtc0 && (bus.waddr_i == REG_COUNT);
        wr_compare = mtc0 && (bus.waddr_i == REG_COMPARE);
        wr_status  = mtc0 && (bus.waddr_i == REG_STATUS);
        wr_cause   = mtc0 && (bus.waddr_i == REG_CAUSE);
        wr_epc     = mtc0 && (bus.waddr_i == REG_EPC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick     <= 1'b0;
            count    <= '0;
            compare  <= '0;
            status   <= STATUS_RST;
            cause    <= '0;
            epc      <= '0;
            badvaddr <= '0;
        end else begin
            tick <= ~tick;
            cause[15:10] <= {bus.int_i[5] | timer_int, bus.int_i[4:0]};

            // A write to Count replaces that cycle's increment.
            if (wr_count)
                count <= bus.data_i;
            else if (tick)
                count <= count + 32'd1;

            if (wr_compare)
                compare <= bus.data_i;

            if (trap)
                status[1] <= 1'b1;
            else if (eret)
                status[1] <= 1'b0;
            else if (wr_status)
                status <= (status & ~STATUS_WMASK) | (bus.data_i & STATUS_WMASK);

            // EPC and BD are only captured when not already at exception level.
            if (trap) begin
                cause[6:2] <= exc_code(bus.excepttype_i);
                if (!status[1])
                    cause[31] <= bus.is_in_delayslot_i;
            end else if (wr_cause) begin
                cause[9:8] <= bus.data_i[9:8];
            end

            if (trap && !status[1])
                epc <= bus.is_in_delayslot_i ? bus.current_inst_addr_i - 32'd4
                                             : bus.current_inst_addr_i;
            else if (wr_epc)
                epc <= bus.data_i;

            if (trap && (bus.excepttype_i == 32'h4 || bus.excepttype_i == 32'h5))
                badvaddr <= bus.bad_addr_i;
        end
    end

`ifdef CP0_TIMER_INT_EN
    // Sticky until software rewrites Compare.
    always_ff @(posedge clk) begin
        if (rst)
            timer_int <= 1'b0;
        else if (wr_compare)
            timer_int <= 1'b0;
        else if (count == compare && compare != 32'h0)
            timer_int <= 1'b1;
    end
`else
    assign timer_int = 1'b0;
`endif

    always_comb begin
        case (bus.raddr_i)
            REG_BADVADDR: bus.data_o = badvaddr;
            REG_COUNT:    bus.data_o = count;
            REG_COMPARE:  bus.data_o = compare;
            REG_STATUS:   bus.data_o = status;
            REG_CAUSE:    bus.data_o = cause;
            REG_EPC:      bus.data_o = epc;
            default:      bus.data_o = 32'h0;
        endcase
    end

    assign bus.count_o     = count;
    assign bus.compare_o   = compare;
    assign bus.status_o    = status;
    assign bus.cause_o     = cause;
    assign bus.epc_o       = epc;
    assign bus.badvaddr_o  = badvaddr;
    assign bus.timer_int_o = timer_int;
endmodule
